// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the accumulator-ALU issue stage.
// Select codes, FSM states, the buffered request format and flag helpers.
package alu_seq_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_LDA = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_LDB = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      HOLD = 2'b10
   } state_t;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] a;
      logic [7:0] b;
   } req_t;

   // Add reports carry-out and subtract reports borrow, both on bit 8.
   function automatic logic calc_carry(input logic [1:0] sel, input logic c_msb);
      return ((sel == ALU_ADD) || (sel == ALU_SUB)) ? c_msb : 1'b0;
   endfunction

   // Loads have no meaningful result byte, so zero looks at the accumulator.
   function automatic logic calc_zero(input logic [1:0] sel, input logic [7:0] c_low,
                                      input logic [7:0] acc);
      return ((sel == ALU_ADD) || (sel == ALU_SUB)) ? (c_low == 8'h00) : (acc == 8'h00);
   endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  req_t wdata,
   input  logic pop,
   output req_t rdata,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   req_t           mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit accumulator ALU: buffers requests, drives the ALU
// one op at a time, and presents results. Optional counters: ALU_SEQ_STATS_EN.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_sel,
   input  logic [7:0]  op_a,
   input  logic [7:0]  op_b,
   output logic [1:0]  alu_sel,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic [8:0]  alu_c,
   input  logic [7:0]  alu_acc,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [8:0]  res_c,
   output logic [7:0]  res_acc,
   output logic [1:0]  res_sel,
   output logic        res_carry,
   output logic        res_zero
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0] stat_ops,
   output logic [15:0] stat_carry
`endif
);

   state_t state;
   state_t state_nxt;
   req_t   fifo_wdata;
   req_t   fifo_rdata;
   logic   fifo_full;
   logic   fifo_empty;
   logic   pop;
   logic   capture;
   logic   release_res;

   assign op_ready   = !fifo_full;
   assign fifo_wdata = '{sel: op_sel, a: op_a, b: op_b};

   alu_seq_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (op_valid),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               release_res = 1'b1;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ALU drive registers move only on a pop, so they stay stable through HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_sel <= ALU_ADD;
         alu_a   <= '0;
         alu_b   <= '0;
      end else if (pop) begin
         alu_sel <= fifo_rdata.sel;
         alu_a   <= fifo_rdata.a;
         alu_b   <= fifo_rdata.b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_c     <= '0;
         res_acc   <= '0;
         res_sel   <= ALU_ADD;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
      end else if (capture) begin
         res_valid <= 1'b1;
         res_c     <= alu_c;
         res_acc   <= alu_acc;
         res_sel   <= alu_sel;
         res_carry <= calc_carry(alu_sel, alu_c[8]);
         res_zero  <= calc_zero(alu_sel, alu_c[7:0], alu_acc);
      end else if (release_res) begin
         res_valid <= 1'b0;
      end
   end

`ifdef ALU_SEQ_STATS_EN
   // Op count wraps naturally; carry count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops   <= '0;
         stat_carry <= '0;
      end else if (release_res) begin
         stat_ops <= stat_ops + 16'd1;
         if (res_carry && (stat_carry != 16'hFFFF)) stat_carry <= stat_carry + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: bench-side ALU, a queue of
// expected results computed from the request values, randomized traffic.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] op_sel;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [1:0] alu_sel;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [8:0] alu_c;
   logic [7:0] alu_acc;
   logic       res_valid;
   logic       res_ready;
   logic [8:0] res_c;
   logic [7:0] res_acc;
   logic [1:0] res_sel;
   logic       res_carry;
   logic       res_zero;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_ops;
   logic [15:0] stat_carry;
`endif

   typedef struct packed {
      logic [1:0] sel;
      logic [8:0] c;
      logic [7:0] acc;
      logic       carry;
      logic       zero;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   hs_count = 0;
   int   carry_count = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_sel    (op_sel),
      .op_a      (op_a),
      .op_b      (op_b),
      .alu_sel   (alu_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c     (alu_c),
      .alu_acc   (alu_acc),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_c     (res_c),
      .res_acc   (res_acc),
      .res_sel   (res_sel),
      .res_carry (res_carry),
      .res_zero  (res_zero)
`ifdef ALU_SEQ_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_carry (stat_carry)
`endif
   );

   // Combinational stand-in for the accumulator ALU.
   always_comb begin
      alu_c   = '0;
      alu_acc = '0;
      case (alu_sel)
         2'b00: begin alu_c = {1'b0, alu_a} + {1'b0, alu_b}; alu_acc = alu_c[7:0]; end
         2'b10: begin alu_c = {1'b0, alu_a} - {1'b0, alu_b}; alu_acc = alu_c[7:0]; end
         2'b01: alu_acc = alu_a;
         default: alu_acc = alu_b;
      endcase
   end

   // Expected result of one request, straight from the operation definitions.
   function automatic exp_t model(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   v;
      e.sel = sel;
      if (sel == 2'b00 || sel == 2'b10) begin
         v       = (sel == 2'b00) ? (int'(a) + int'(b)) : (int'(a) - int'(b));
         e.c     = 9'(v);
         e.acc   = 8'(v);
         e.carry = (sel == 2'b00) ? (v > 255) : (v < 0);
         e.zero  = (8'(v) == 8'h00);
      end else begin
         e.c     = '0;
         e.acc   = (sel == 2'b01) ? a : b;
         e.carry = 1'b0;
         e.zero  = (e.acc == 8'h00);
      end
      return e;
   endfunction

   task automatic push_op(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      while (!op_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!op_ready) begin
         compared++;
         mismatched++;
         $display("FAIL push_timeout op_ready=%b required 1", op_ready);
         return;
      end
      op_valid = 1'b1;
      op_sel   = sel;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      exp_q.push_back(model(sel, a, b));
   endtask

   // Wait for a result, compare it with the queue head, then take it with a one-cycle ready pulse.
   task automatic collect(input string name);
      int   waited = 0;
      exp_t e;
      @(negedge clk);
      while (!res_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      compared++;
      if (res_valid !== 1'b1 || exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL %s_valid res_valid=%b queued=%0d required valid with a queued result",
                  name, res_valid, exp_q.size());
         return;
      end
      e = exp_q.pop_front();
      if ({res_sel, res_c, res_acc, res_carry, res_zero} !== e) begin
         mismatched++;
         $display("FAIL %s got sel=%h c=%h acc=%h carry=%b zero=%b required sel=%h c=%h acc=%h carry=%b zero=%b",
                  name, res_sel, res_c, res_acc, res_carry, res_zero, e.sel, e.c, e.acc, e.carry, e.zero);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      hs_count++;
      if (e.carry) carry_count++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      hs_count    = 0;
      carry_count = 0;
   endtask

   task automatic test_reset();
      op_valid  = 1'b0;
      op_sel    = '0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      do_reset();
      @(negedge clk);
      compared++;
      if ({op_ready, alu_sel, alu_a, alu_b, res_valid, res_c, res_acc, res_sel, res_carry, res_zero}
          !== {1'b1, 40'h0}) begin
         mismatched++;
         $display("FAIL reset_state ready=%b alu=%h/%h/%h res=%b/%h/%h/%h/%b/%b required ready=1 rest 0",
                  op_ready, alu_sel, alu_a, alu_b, res_valid, res_c, res_acc, res_sel, res_carry, res_zero);
      end
   endtask

   // Latency from an idle, empty block: pop one edge after accept, result one edge later.
   task automatic test_add_latency();
      exp_t e;
      res_ready = 1'b1;
      push_op(2'b00, 8'h7F, 8'h01);
      @(negedge clk);
      compared++;
      if (res_valid !== 1'b0 || alu_a !== 8'h00) begin
         mismatched++;
         $display("FAIL latency_no_bypass res_valid=%b alu_a=%h required 0 and 00", res_valid, alu_a);
      end
      @(negedge clk);
      compared++;
      if ({res_valid, alu_sel, alu_a, alu_b} !== {1'b0, 2'b00, 8'h7F, 8'h01}) begin
         mismatched++;
         $display("FAIL latency_pop res_valid=%b alu=%h/%h/%h required 0 00/7f/01",
                  res_valid, alu_sel, alu_a, alu_b);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if ({res_valid, res_c, res_carry, res_zero} !== {1'b1, 9'h080, 1'b0, 1'b0} || res_acc !== e.acc) begin
         mismatched++;
         $display("FAIL latency_result valid=%b c=%h carry=%b zero=%b acc=%h required 1 080 0 0 acc=%h",
                  res_valid, res_c, res_carry, res_zero, res_acc, e.acc);
      end
      @(negedge clk);
      hs_count++;
      compared++;
      if (res_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL latency_handshake res_valid=%b required 0", res_valid);
      end
      res_ready = 1'b0;
      push_op(2'b00, 8'hFF, 8'h01);
      collect("add_carry");
   endtask

   task automatic test_sub();
      push_op(2'b10, 8'h05, 8'h05);
      push_op(2'b10, 8'h03, 8'h05);
      collect("sub_zero");
      collect("sub_borrow");
   endtask

   task automatic test_load();
      push_op(2'b01, 8'h3C, 8'($urandom));
      push_op(2'b11, 8'($urandom), 8'hA5);
      collect("load_a");
      collect("load_b");
   endtask

   // Five requests with the result stalled: one executes, four fill the buffer.
   task automatic test_backpressure();
      logic [8:0] held_c;
      logic [7:0] held_a;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_op(2'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      held_c = res_c;
      held_a = alu_a;
      compared++;
      if (op_ready !== 1'b0 || res_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL full_ready op_ready=%b res_valid=%b required 0 and 1", op_ready, res_valid);
      end
      repeat (3) @(negedge clk);
      compared++;
      if (res_c !== held_c || alu_a !== held_a || res_valid !== 1'b1 || op_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL hold_stable res_c=%h alu_a=%h valid=%b ready=%b required %h %h 1 0",
                  res_c, alu_a, res_valid, op_ready, held_c, held_a);
      end
      for (int i = 0; i < 5; i++) collect("drain");
      compared++;
      if (op_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL drained_ready op_ready=%b required 1", op_ready);
      end
   endtask

   // With res_ready held high, results alternate valid/idle every cycle.
   task automatic test_back_to_back();
      int   waited = 0;
      exp_t e;
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_op(2'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      while (!res_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         compared++;
         if (k % 2 == 0) begin
            if (exp_q.size() == 0) e = '0;
            else e = exp_q.pop_front();
            if (res_valid !== 1'b1 || {res_sel, res_c, res_acc, res_carry, res_zero} !== e) begin
               mismatched++;
               $display("FAIL b2b_result_%0d valid=%b c=%h acc=%h required valid c=%h acc=%h",
                        k / 2, res_valid, res_c, res_acc, e.c, e.acc);
            end
            hs_count++;
            if (e.carry) carry_count++;
         end else if (res_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap_%0d res_valid=%b required 0", k / 2, res_valid);
         end
         @(negedge clk);
      end
      res_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int r = 0; r < 12; r++) begin
         int n = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) push_op(2'($urandom), 8'($urandom), 8'($urandom));
         for (int i = 0; i < n; i++) collect("random");
      end
`ifdef ALU_SEQ_STATS_EN
      @(negedge clk);
      compared++;
      if (stat_ops !== 16'(hs_count) || stat_carry !== 16'(carry_count)) begin
         mismatched++;
         $display("FAIL stats stat_ops=%0d stat_carry=%0d required %0d %0d",
                  stat_ops, stat_carry, hs_count, carry_count);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int waited = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_op(2'b00, 8'($urandom), 8'($urandom));
      @(negedge clk);
      while (!res_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      compared++;
      if ({op_ready, alu_sel, alu_a, alu_b, res_valid, res_c, res_acc, res_sel, res_carry, res_zero}
          !== {1'b1, 40'h0}) begin
         mismatched++;
         $display("FAIL reset_mid ready=%b alu=%h/%h/%h res=%b/%h/%h/%h/%b/%b required ready=1 rest 0",
                  op_ready, alu_sel, alu_a, alu_b, res_valid, res_c, res_acc, res_sel, res_carry, res_zero);
      end
`ifdef ALU_SEQ_STATS_EN
      compared++;
      if (stat_ops !== 16'h0) begin
         mismatched++;
         $display("FAIL reset_stats stat_ops=%0d required 0", stat_ops);
      end
`endif
      res_ready = 1'b1;
      waited = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || alu_a !== 8'h00) waited++;
      end
      compared++;
      if (waited != 0) begin
         mismatched++;
         $display("FAIL reset_no_stale cycles_with_activity=%0d required 0", waited);
      end
      res_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      test_reset();
      test_add_latency();
      test_sub();
      test_load();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream issue stage for the 8-bit accumulator ALU. It accepts operation requests (select code plus two 8-bit operands) over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's `sel`/`A`/`B` inputs from registers, one operation at a time, then captures the ALU's 9-bit result and 8-bit accumulator into an output register. It presents that result with flags on a second valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request buffer depth; must be a power of two, at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `op_valid`  in  1: request present.
- `op_ready`  out  1: request can be accepted; equals FIFO not full.
- `op_sel`  in  2: ALU select; 00 add, 01 load A into accumulator, 10 subtract, 11 load B into accumulator.
- `op_a`, `op_b`  in  8 each: operands.
- `alu_sel`  out  2: registered select driven to the ALU.
- `alu_a`, `alu_b`  out  8 each: registered operands driven to the ALU.
- `alu_c`  in  9: ALU result.
- `alu_acc`  in  8: ALU accumulator.
- `res_valid`  out  1: result register holds an uncollected result.
- `res_ready`  in  1: consumer takes the result.
- `res_c`  out  9: captured `alu_c`.
- `res_acc`  out  8: captured `alu_acc`.
- `res_sel`  out  2: select of the captured operation.
- `res_carry`  out  1: `res_c[8]` for add; borrow (`res_c[8]`) for subtract; 0 for the load operations.
- `res_zero`  out  1: `res_c[7:0]==0` for add/subtract; `res_acc==0` for the load operations.

## Operation
- A request is accepted on a rising edge where `op_valid && op_ready`. It is written to the FIFO tail.
- `op_ready` depends only on FIFO fullness. It is 0 when the FIFO is full, even if a pop happens in the same cycle.
- A push into an empty FIFO does not bypass the FIFO. The entry becomes poppable on the next cycle.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head into `alu_sel`/`alu_a`/`alu_b` and go to EXEC. Otherwise stay in IDLE.
  - EXEC: the ALU settles combinationally. At the closing edge, capture `alu_c`, `alu_acc`, `alu_sel` and the flags into the result registers, set `res_valid`, and go to HOLD.
  - HOLD: while `res_ready`=0, hold all result outputs and the ALU drive registers stable. On an edge with `res_ready`=1, clear `res_valid`. If the FIFO is non-empty, pop the next entry directly into the ALU drive registers and go to EXEC; otherwise go to IDLE.
- `alu_*` registers change only on a pop or on reset.
- Arithmetic: the sequencer never modifies ALU results. It only forms the flags.
- Operand and select values pass through the FIFO unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. They wrap modulo 2·FIFO_DEPTH, and full/empty is derived from the pointer MSB.

## Timing
- Reset values: `op_ready`=1, `alu_sel`=00, `alu_a`=`alu_b`=0, `res_valid`=0, `res_c`=0, `res_acc`=0, `res_sel`=00, `res_carry`=0, `res_zero`=0. FIFO is empty; state is IDLE.
- Reset asserted mid-operation (EXEC or HOLD): the FIFO contents and any pending result are discarded. All outputs return to their reset values at that edge.
- Latency from acceptance into an empty, idle block:
  - accept at edge N;
  - pop at edge N+1;
  - `res_valid`=1 after edge N+2.
- Back-to-back throughput with `res_ready` held high: one result every 2 cycles (EXEC, HOLD, EXEC, …).
- `res_ready` with `res_valid`=0 has no effect.

## Configuration
- `ALU_SEQ_STATS_EN` defined: adds two outputs.
  - `stat_ops` (16 bit): increments on every result handshake and wraps at 0xFFFF→0.
  - `stat_carry` (16 bit): increments on every result handshake with `res_carry`=1 and saturates at 0xFFFF.
  - Both reset to 0.
- `ALU_SEQ_STATS_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package `alu_seq_pkg`:
  - select constants `ALU_ADD`=00, `ALU_LDA`=01, `ALU_SUB`=10, `ALU_LDB`=11;
  - state enum {IDLE, EXEC, HOLD};
  - a packed request struct {sel, a, b}.
- Sub-module `alu_seq_fifo`: the parameterised synchronous FIFO of request structs, with push, pop, full and empty. The FSM, ALU drive registers and result register live in the top module.

## Test plan
- Reset, then push {00, 0x7F, 0x01} with a bench ALU model and `res_ready`=1 → after edge N+2: `res_valid`=1, `res_c`=0x080, `res_carry`=0, `res_zero`=0.
- Push {00, 0xFF, 0x01} → `res_c`=0x100, `res_carry`=1, `res_zero`=1.
- Push {10, 0x05, 0x05}, then {10, 0x03, 0x05} → `res_c`=0x000 with `res_zero`=1; then `res_c`=0x1FE with `res_carry`=1.
- Hold `res_ready`=0 and push 5 requests → `op_ready`=0 after 4 are buffered (1 executing plus 4 queued). Releasing `res_ready` drains all 5 results in order with unchanged values.
- Push {01, 0x3C, x}, then {11, x, 0xA5} → `res_acc`=0x3C, then 0xA5; `res_c`=0; `res_carry`=0.
- Assert `rst` while in HOLD with 2 entries queued → next cycle all outputs are at reset values, the FIFO is empty, and no stale result appears afterwards. With `ALU_SEQ_STATS_EN`, `stat_ops`=0.
